dmem_responder: RTL and testbench

Multi-cycle data-memory responder. It is the target side of the CPU load/store interface and replaces the zero-wait DMEM when a core needs a memory with wait states.
- Accepts one request at a time over a valid/ready handshake.
- Performs byte/half/word access with RV32I load extension.
- Returns the response after a programmable latency, with error signalling for misaligned, out-of-range and illegal-size accesses.

---
 rtl/dmem_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over valid/ready,
// RV32I byte/half/word lanes, response after LATENCY cycles with fault reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
        if (DEPTH_WORDS < 1) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             size_ok;
    logic             misaligned;
    logic             out_of_range;
    logic             dec_err;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rd_word;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  offs,
                                                input logic [2:0]  size);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offs)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offs[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Request decode; a single error bit covers size, alignment and range faults.
    always_comb begin
        size_ok      = 1'b0;
        misaligned   = 1'b0;
        be           = 4'b0000;
        wdata_lanes  = req_wdata;

        case (req_size)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !req_we;
            default:                size_ok = 1'b0;
        endcase

        case (req_size[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        dec_err      = !size_ok || misaligned || out_of_range;
        idx          = out_of_range ? '0 : req_addr[IDX_W+1:2];

        case (req_size[1:0])
            2'b00: begin
                be          = 4'b0001 << req_addr[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be          = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = req_wdata;
            end
        endcase
    end

    assign accept  = req_valid && req_ready && !rst;
    assign rd_word = mem[idx];

    // Storage is never reset; only clean stores commit, on the accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_we && !dec_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_err   <= dec_err;
                        rsp_rdata <= (dec_err || req_we) ? '0
                                   : load_extend(rd_word, req_addr[1:0], req_size);
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) checked against a
// byte-addressed reference memory model.
module tb_dmem_responder;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } op_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        stable;
        logic        post_ok;
    } obs_t;

    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  req_size  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    logic [7:0]  mb [3][4096];
    int          errors = 0;
    int          checks = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_size(req_size[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_size(req_size[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut2 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_size(req_size[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory is a plain byte array; a load gathers bytes and extends.
    task automatic model(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size,
                         output logic [31:0] rdata, output logic err);
        int          n;
        int          base;
        logic        legal;
        logic [31:0] v;
        legal = we ? (size <= 3'd2) : (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << size[1:0];
        rdata = '0;
        err   = 1'b0;
        if (!legal || (addr % n) != 0 || (addr / 4) >= 32'd1024) begin
            err = 1'b1;
        end else begin
            base = int'(addr[11:0]);
            if (we) begin
                for (int i = 0; i < n; i++) mb[d][base + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][base + i];
                if (!size[2] && n < 4 && v[8*n - 1]) begin
                    for (int j = 8 * n; j < 32; j++) v[j] = 1'b1;
                end
                rdata = v;
            end
        end
    endtask

    // One transaction: present request, measure latency, optionally stall the response.
    task automatic drive(input int d, input op_t op, input int hold, output obs_t o);
        int guard;
        o = '0;
        o.lat = -1;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = op.we;
        req_addr[d]  = op.addr;
        req_wdata[d] = op.wdata;
        req_size[d]  = op.size;
        rsp_ready[d] = 1'b0;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_size[d]  = 3'($urandom);
        o.lat = 0;
        do begin
            @(negedge clk);
            o.lat++;
        end while (rsp_valid[d] !== 1'b1 && o.lat < 40);
        req_valid[d] = 1'b0;
        if (rsp_valid[d] !== 1'b1) begin
            o.lat = -1;
            return;
        end
        o.rdata  = rsp_rdata[d];
        o.err    = rsp_err[d];
        o.stable = (req_ready[d] === 1'b0);
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== o.rdata ||
                rsp_err[d] !== o.err || req_ready[d] !== 1'b0) o.stable = 1'b0;
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        o.post_ok = (rsp_valid[d] === 1'b0) && (req_ready[d] === 1'b1) &&
                    (rsp_rdata[d] === 32'h0) && (rsp_err[d] === 1'b0);
    endtask

    task automatic test_reset();
        obs_t        o;
        op_t         w;
        logic [31:0] mr;
        logic        me;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b1; req_we[d] = 1'b1;
            req_addr[d] = 32'h40; req_wdata[d] = 32'hBAD0BAD0; req_size[d] = 3'b010;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset%0d req_ready: got %b expected 1", d, req_ready[d]); end
            checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset%0d rsp_valid: got %b expected 0", d, rsp_valid[d]); end
            checks++; if (rsp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset%0d rsp_rdata: got %h expected 0", d, rsp_rdata[d]); end
            checks++; if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL reset%0d rsp_err: got %b expected 0", d, rsp_err[d]); end
            rst[d] = 1'b0; req_valid[d] = 1'b0;
        end
        w = '{1'b1, 32'h40, 32'h600DCAFE, 3'b010, 32'h0, 1'b0};
        drive(0, w, 0, o); model(0, w.we, w.addr, w.wdata, w.size, mr, me);
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL reset store err: got %b expected 0", o.err); end
        @(negedge clk);
        rst[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0] = 32'h40; req_wdata[0] = 32'hBAD0BAD0; req_size[0] = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset hold: got ready=%b valid=%b expected ready=1 valid=0", req_ready[0], rsp_valid[0]); end
        rst[0] = 1'b0; req_valid[0] = 1'b0;
        w = '{1'b0, 32'h40, 32'h0, 3'b010, 32'h600DCAFE, 1'b0};
        drive(0, w, 0, o); model(0, w.we, w.addr, w.wdata, w.size, mr, me);
        checks++; if (o.rdata !== 32'h600DCAFE) begin errors++; $display("FAIL reset no-accept: got %h expected 600dcafe", o.rdata); end
        checks++; if (o.lat !== 2) begin errors++; $display("FAIL reset load latency: got %0d expected 2", o.lat); end
    endtask

    task automatic test_word_round_trip();
        op_t         tbl [4];
        obs_t        o;
        logic [31:0] mr;
        logic        me;
        tbl = '{'{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0},
                '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
                '{1'b1, 32'hFFC, 32'h0BADF00D, 3'b010, 32'h0,        1'b0},
                '{1'b0, 32'hFFC, 32'h0,        3'b010, 32'h0BADF00D, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            drive(0, tbl[i], 0, o); model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, mr, me);
            checks++; if (o.lat !== 2) begin errors++; $display("FAIL word[%0d] latency: got %0d expected 2", i, o.lat); end
            checks++; if (o.rdata !== tbl[i].exp_rdata) begin errors++; $display("FAIL word[%0d] rdata: got %h expected %h", i, o.rdata, tbl[i].exp_rdata); end
            checks++; if (o.err !== tbl[i].exp_err) begin errors++; $display("FAIL word[%0d] err: got %b expected %b", i, o.err, tbl[i].exp_err); end
            checks++; if (o.post_ok !== 1'b1) begin errors++; $display("FAIL word[%0d] after handshake: got %b expected 1", i, o.post_ok); end
        end
    endtask

    task automatic test_byte_lanes();
        op_t         tbl [8];
        obs_t        o;
        logic [31:0] mr;
        logic        me;
        tbl = '{'{1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0,        1'b0},
                '{1'b1, 32'h21, 32'hCDCDCDAB, 3'b000, 32'h0,        1'b0},
                '{1'b1, 32'h22, 32'h77778001, 3'b001, 32'h0,        1'b0},
                '{1'b0, 32'h20, 32'h0,        3'b010, 32'h8001AB44, 1'b0},
                '{1'b0, 32'h21, 32'h0,        3'b000, 32'hFFFFFFAB, 1'b0},
                '{1'b0, 32'h21, 32'h0,        3'b100, 32'h000000AB, 1'b0},
                '{1'b0, 32'h22, 32'h0,        3'b001, 32'hFFFF8001, 1'b0},
                '{1'b0, 32'h22, 32'h0,        3'b101, 32'h00008001, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            drive(0, tbl[i], 0, o); model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, mr, me);
            checks++; if (o.lat !== 2) begin errors++; $display("FAIL lanes[%0d] latency: got %0d expected 2", i, o.lat); end
            checks++; if (o.rdata !== tbl[i].exp_rdata) begin errors++; $display("FAIL lanes[%0d] rdata: got %h expected %h", i, o.rdata, tbl[i].exp_rdata); end
            checks++; if (o.err !== tbl[i].exp_err) begin errors++; $display("FAIL lanes[%0d] err: got %b expected %b", i, o.err, tbl[i].exp_err); end
            checks++; if (o.post_ok !== 1'b1) begin errors++; $display("FAIL lanes[%0d] after handshake: got %b expected 1", i, o.post_ok); end
        end
    endtask

    task automatic test_errors();
        op_t         tbl [9];
        obs_t        o;
        logic [31:0] mr;
        logic        me;
        tbl = '{'{1'b0, 32'h13,   32'h0,        3'b010, 32'h0,        1'b1},
                '{1'b1, 32'h21,   32'h0000FFFF, 3'b001, 32'h0,        1'b1},
                '{1'b0, 32'h20,   32'h0,        3'b010, 32'h8001AB44, 1'b0},
                '{1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1},
                '{1'b0, 32'h20,   32'h0,        3'b011, 32'h0,        1'b1},
                '{1'b1, 32'h20,   32'h0,        3'b100, 32'h0,        1'b1},
                '{1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, 32'h0,        1'b1},
                '{1'b0, 32'h23,   32'h0,        3'b001, 32'h0,        1'b1},
                '{1'b0, 32'h20,   32'h0,        3'b010, 32'h8001AB44, 1'b0}};
        for (int i = 0; i < 9; i++) begin
            drive(0, tbl[i], 0, o); model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, mr, me);
            checks++; if (o.lat !== 2) begin errors++; $display("FAIL errs[%0d] latency: got %0d expected 2", i, o.lat); end
            checks++; if (o.rdata !== tbl[i].exp_rdata) begin errors++; $display("FAIL errs[%0d] rdata: got %h expected %h", i, o.rdata, tbl[i].exp_rdata); end
            checks++; if (o.err !== tbl[i].exp_err) begin errors++; $display("FAIL errs[%0d] err: got %b expected %b", i, o.err, tbl[i].exp_err); end
            checks++; if (o.post_ok !== 1'b1) begin errors++; $display("FAIL errs[%0d] after handshake: got %b expected 1", i, o.post_ok); end
        end
    endtask

    task automatic test_backpressure();
        op_t  w;
        obs_t o;
        w = '{1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0};
        drive(0, w, 5, o);
        checks++; if (o.lat !== 2) begin errors++; $display("FAIL stall latency: got %0d expected 2", o.lat); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL stall stability: got %b expected 1", o.stable); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stall rdata: got %h expected deadbeef", o.rdata); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL stall err: got %b expected 0", o.err); end
        checks++; if (o.post_ok !== 1'b1) begin errors++; $display("FAIL stall release: got %b expected 1", o.post_ok); end
    endtask

    task automatic test_back_to_back();
        op_t         w;
        obs_t        o;
        logic [31:0] mr;
        logic        me;
        logic        pend;
        int          acc [$];
        int          vld [$];
        logic [31:0] dat [$];
        w = '{1'b1, 32'h0, 32'hA5A50001, 3'b010, 32'h0, 1'b0};
        drive(1, w, 0, o); model(1, w.we, w.addr, w.wdata, w.size, mr, me);
        checks++; if (o.lat !== 1) begin errors++; $display("FAIL b2b store0 latency: got %0d expected 1", o.lat); end
        w = '{1'b1, 32'h4, 32'h5A5A0002, 3'b010, 32'h0, 1'b0};
        drive(1, w, 0, o); model(1, w.we, w.addr, w.wdata, w.size, mr, me);
        checks++; if (o.lat !== 1) begin errors++; $display("FAIL b2b store1 latency: got %0d expected 1", o.lat); end
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0;
        req_size[1] = 3'b010; rsp_ready[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid[1] === 1'b1) begin
                vld.push_back(c);
                dat.push_back(rsp_rdata[1]);
            end
            pend = req_valid[1] && (req_ready[1] === 1'b1);
            if (pend) acc.push_back(c);
            @(posedge clk);
            #1;
            if (pend) begin
                if (acc.size() == 1) req_addr[1] = 32'h4;
                else req_valid[1] = 1'b0;
            end
            @(negedge clk);
        end
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b0;
        checks++;
        if (acc.size() != 2 || vld.size() != 2) begin
            errors++; $display("FAIL b2b counts: got accepts=%0d responses=%0d expected 2 and 2", acc.size(), vld.size());
        end else begin
            checks++; if (acc[1] - acc[0] != 2) begin errors++; $display("FAIL b2b spacing: got %0d expected 2", acc[1] - acc[0]); end
            checks++; if (vld[0] != acc[0] + 1 || vld[1] != acc[1] + 1) begin errors++; $display("FAIL b2b latency: got %0d,%0d expected 1,1", vld[0] - acc[0], vld[1] - acc[1]); end
            checks++; if (dat[0] !== 32'hA5A50001) begin errors++; $display("FAIL b2b data0: got %h expected a5a50001", dat[0]); end
            checks++; if (dat[1] !== 32'h5A5A0002) begin errors++; $display("FAIL b2b data1: got %h expected 5a5a0002", dat[1]); end
        end
    endtask

    task automatic test_midop_reset();
        op_t         w;
        obs_t        o;
        logic [31:0] mr;
        logic        me;
        logic        ok;
        int          guard;
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h30;
        req_wdata[2] = 32'h5A5A5A5A; req_size[2] = 3'b010; rsp_ready[2] = 1'b0;
        guard = 0;
        while (req_ready[2] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (guard >= 50) begin errors++; $display("FAIL midrst accept: got no req_ready expected req_ready=1"); end
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        model(2, 1'b1, 32'h30, 32'h5A5A5A5A, 3'b010, mr, me);
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrst idle: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid[2], req_ready[2]); end
        w = '{1'b0, 32'h30, 32'h0, 3'b010, 32'h5A5A5A5A, 1'b0};
        drive(2, w, 0, o);
        checks++; if (o.lat !== 4) begin errors++; $display("FAIL midrst latency: got %0d expected 4", o.lat); end
        checks++; if (o.rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL midrst committed: got %h expected 5a5a5a5a", o.rdata); end
    endtask

    task automatic test_random();
        op_t         w;
        obs_t        o;
        logic [31:0] mr;
        logic        me;
        int          hold;
        for (int i = 0; i < 76; i++) begin
            if (i < 16) begin
                w = '{1'b1, 32'(4 * i), $urandom, 3'b010, 32'h0, 1'b0};
                hold = 0;
            end else begin
                w.we    = 1'($urandom);
                w.size  = 3'($urandom_range(0, 7));
                w.wdata = $urandom;
                if ($urandom_range(0, 4) != 0) w.addr = 32'($urandom_range(0, 63));
                else if ($urandom_range(0, 1) == 0) w.addr = 32'($urandom_range(32'h1000, 32'h1100));
                else w.addr = $urandom;
                hold = $urandom_range(0, 2);
            end
            model(0, w.we, w.addr, w.wdata, w.size, mr, me);
            drive(0, w, hold, o);
            checks++; if (o.lat !== 2) begin errors++; $display("FAIL rand[%0d] latency: got %0d expected 2", i, o.lat); end
            checks++; if (o.rdata !== mr) begin errors++; $display("FAIL rand[%0d] rdata we=%b size=%0d addr=%h: got %h expected %h", i, w.we, w.size, w.addr, o.rdata, mr); end
            checks++; if (o.err !== me) begin errors++; $display("FAIL rand[%0d] err we=%b size=%0d addr=%h: got %b expected %b", i, w.we, w.size, w.addr, o.err, me); end
            checks++; if (o.stable !== 1'b1 || o.post_ok !== 1'b1) begin errors++; $display("FAIL rand[%0d] handshake: got stable=%b post=%b expected 1 1", i, o.stable, o.post_ok); end
        end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_midop_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
